// File: rtl/round_robin_arbiter_wrr.sv
// Weighted round-robin arbiter: a granted port holds the grant for up to its
// weight in acknowledged beats, then priority rotates to the next port.
module round_robin_arbiter_wrr #(
    parameter int NUM_PORTS = 16,
    parameter int WEIGHT_W  = 4,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
    input  logic                          ack_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    output logic                          gnt_valid_o,
    output logic [IDX_W-1:0]              gnt_idx_o,
    output logic [WEIGHT_W-1:0]           credit_o,
    output logic [0:0]                    fsm_state
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_PORTS-1:0] gnt_q;
    logic [WEIGHT_W-1:0]  credit_q;

    logic                 release_now;
    logic [IDX_W-1:0]     next_ptr;
    logic [IDX_W-1:0]     arb_ptr;
    logic                 any_req;
    logic                 hi_found;
    logic [IDX_W-1:0]     hi_idx;
    logic [IDX_W-1:0]     lo_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic [WEIGHT_W-1:0]  sel_weight;
    logic [WEIGHT_W-1:0]  load_credit;
    logic [NUM_PORTS-1:0] sel_onehot;

    // Handshake: ack_i means the downstream consumed one beat from the port
    // currently on gnt_o; it only has meaning while a grant is held.
    assign release_now = (state == GRANT) &&
                         (!req_i[idx_q] || (ack_i && (credit_q == WEIGHT_W'(1))));

    assign next_ptr = (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + 1'b1;
    assign arb_ptr  = release_now ? next_ptr : ptr;
    assign any_req  = |req_i;

    // Descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= arb_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign sel_idx = hi_found ? hi_idx : lo_idx;

    always_comb begin
        sel_weight = '0;
        sel_onehot = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (IDX_W'(p) == sel_idx) begin
                sel_weight    = weight_i[p*WEIGHT_W +: WEIGHT_W];
                sel_onehot[p] = 1'b1;
            end
        end
    end

    // A zero weight still buys one beat so such a port is never locked out.
    assign load_credit = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            idx_q    <= '0;
            gnt_q    <= '0;
            credit_q <= '0;
        end else if ((state == IDLE) || release_now) begin
            if (release_now) begin
                ptr <= next_ptr;
            end
            if (any_req) begin
                state    <= GRANT;
                gnt_q    <= sel_onehot;
                idx_q    <= sel_idx;
                credit_q <= load_credit;
            end else begin
                state    <= IDLE;
                gnt_q    <= '0;
                idx_q    <= '0;
                credit_q <= '0;
            end
        end else if (ack_i) begin
            credit_q <= credit_q - 1'b1;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = |gnt_q;
    assign gnt_idx_o   = idx_q;
    assign credit_o    = credit_q;
    assign fsm_state   = state;

endmodule

// File: doc/round_robin_arbiter_wrr.md
ROUND_ROBIN_ARBITER_WRR -- requirements
Module: round_robin_arbiter_wrr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 16, number of requesters (2..32).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-port weight field.
REQ-003 SHALL derive IDX_W = $clog2(NUM_PORTS) for index outputs.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_i  input  NUM_PORTS  per-port request, level-sensitive.
REQ-007 SHALL have port weight_i  input  NUM_PORTS*WEIGHT_W  per-port grant quota; port p at bits [p*WEIGHT_W +: WEIGHT_W].
REQ-008 SHALL have port ack_i  input  1  downstream accepted one beat from the granted port this cycle.
REQ-009 SHALL have port gnt_o  output  NUM_PORTS  registered one-hot grant.
REQ-010 SHALL have port gnt_valid_o  output  1  high when gnt_o is non-zero.
REQ-011 SHALL have port gnt_idx_o  output  IDX_W  binary index of granted port; 0 when gnt_valid_o low.
REQ-012 SHALL have port credit_o  output  WEIGHT_W  remaining beats of the current grant.

Function
REQ-013 SHALL implement two states: IDLE (no grant) and GRANT (one port holds gnt_o).
REQ-014 SHALL keep a priority pointer ptr (IDX_W bits); arbitration picks the first requesting port at index >= ptr, else the lowest requesting index (wrap-around).
REQ-015 IDLE: if any req_i bit high, SHALL register the selected grant, enter GRANT and load credit = weight of selected port (weight 0 treated as 1); grant visible the cycle after the request (latency 1).
REQ-016 IDLE with req_i == 0: SHALL stay IDLE, outputs unchanged at zero.
REQ-017 GRANT: gnt_o SHALL hold stable while the granted req_i bit stays high and credit is not exhausted, regardless of other requests.
REQ-018 GRANT with ack_i high and credit > 1: SHALL decrement credit by 1 and keep the grant.
REQ-019 GRANT with ack_i high and credit == 1: SHALL release; ptr <= (idx+1) mod NUM_PORTS; re-arbitrate the same cycle with the updated ptr, so the next grant (possibly the same port if it is the sole requester) appears on the following cycle with no idle bubble.
REQ-020 GRANT with granted req_i bit low (with or without ack_i): SHALL release exactly as REQ-019 (ptr advance, same-cycle re-arbitration).
REQ-021 On release with no other requests pending, SHALL enter IDLE and drive gnt_o = 0, gnt_idx_o = 0, credit_o = 0.
REQ-022 ack_i in IDLE SHALL be ignored.
REQ-023 weight_i SHALL be sampled only at grant load; changes during GRANT SHALL not affect current credit.
REQ-024 gnt_o SHALL never have more than one bit set; gnt_valid_o SHALL equal |gnt_o in every cycle.
REQ-025 No port with req_i held high SHALL wait longer than the sum of the other ports' effective weights in acked beats (starvation-free).

Reset
REQ-026 While reset_n low, SHALL force state IDLE, ptr = 0, credit = 0, gnt_o = 0, gnt_valid_o = 0, gnt_idx_o = 0, credit_o = 0, asynchronously.
REQ-027 Reset asserted mid-grant SHALL drop the grant immediately; first arbitration after deassertion SHALL start from ptr = 0.

Verification (NUM_PORTS=4, WEIGHT_W=4)
REQ-028 All weights 1, req_i=4'b1111, ack_i high every cycle -> gnt_idx_o sequence 0,1,2,3,0 on consecutive cycles, no gaps.
REQ-029 Weights {p0=3,p1=1}, req_i=4'b0011, ack_i constant high -> gnt_o 0001 for 3 cycles, 0010 for 1 cycle, repeat; credit_o 3,2,1,1.
REQ-030 Port 2 granted, credit 4, req_i[2] drops with ack_i low -> next cycle grant moves to next requester >= 3 (wrap), ptr = 3.
REQ-031 Weight 0 on port 1, only req_i[1] high, ack_i high -> gnt_o 0010 every cycle, credit_o = 1 each load.
REQ-032 req_i=4'b1000, grant active, reset_n pulsed low for 1 cycle -> gnt_o 0 immediately; after release grant 1000 returns one cycle later with ptr starting at 0.
REQ-033 ack_i high with req_i = 0 from reset -> gnt_valid_o stays 0, credit_o stays 0.
